// File: rtl/arb_pkg.sv
// Shared constants, state encoding and response-frame helper for the
// arbitrage frame sequencer.
package arb_pkg;

    localparam logic [7:0] HDR_BYTE_DEF = 8'hAA;
    localparam logic [7:0] FTR_BYTE_DEF = 8'h55;

    localparam logic [1:0] ACT_NONE  = 2'd0;
    localparam logic [1:0] ACT_BUY_A = 2'd1;
    localparam logic [1:0] ACT_BUY_B = 2'd2;

    localparam int unsigned RESP_LEN = 5;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_PA_HI    = 4'd1,
        ST_PA_LO    = 4'd2,
        ST_PB_HI    = 4'd3,
        ST_PB_LO    = 4'd4,
        ST_FOOTER   = 4'd5,
        ST_LAUNCH   = 4'd6,
        ST_WAIT_CMP = 4'd7,
        ST_TX_LOAD  = 4'd8,
        ST_TX_GAP   = 4'd9,
        ST_TX_WAIT  = 4'd10
    } state_e;

    // Byte idx of the response frame {HDR, action, profit_hi, profit_lo, FTR}.
    function automatic logic [7:0] resp_byte(
        input logic [2:0]  idx,
        input logic [1:0]  action,
        input logic [15:0] profit,
        input logic [7:0]  hdr,
        input logic [7:0]  ftr
    );
        logic [7:0] b;
        case (idx)
            3'd0:    b = hdr;
            3'd1:    b = {6'b000000, action};
            3'd2:    b = profit[15:8];
            3'd3:    b = profit[7:0];
            3'd4:    b = ftr;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/arb_frame_controller_rx_gap_timer.sv
// Inter-byte gap timer: counts enabled cycles since the last clear and
// saturates at TIMEOUT_CYC, where it reports expiry.
module rx_gap_timer #(
    parameter int unsigned TIMEOUT_CYC = 104160
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned W = $clog2(TIMEOUT_CYC + 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign expired = (count_q == W'(TIMEOUT_CYC));

    // Next count: clear wins, then count up until saturation.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = {W{1'b0}};
        end else if (enable && !expired) begin
            count_d = count_q + W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/arb_frame_controller.sv
// Frame sequencer: parses inbound price frames, launches one compare per
// accepted frame and serialises the response frame into the UART transmitter.
module arb_frame_controller
    import arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 104160,
    parameter logic [7:0]  HDR_BYTE    = HDR_BYTE_DEF,
    parameter logic [7:0]  FTR_BYTE    = FTR_BYTE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [15:0] cmp_price_a,
    output logic [15:0] cmp_price_b,
    output logic        cmp_start,
    input  logic        cmp_done,
    input  logic [1:0]  cmp_action,
    input  logic [15:0] cmp_profit,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic        frame_ok,
    output logic        frame_err,
    output logic        rx_drop
);

    state_e      state_q, state_d;
    logic [15:0] a_stage_q, a_stage_d;
    logic [15:0] b_stage_q, b_stage_d;
    logic [15:0] price_a_q, price_a_d;
    logic [15:0] price_b_q, price_b_d;
    logic [1:0]  action_q, action_d;
    logic [15:0] profit_q, profit_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_start_q, tx_start_d;
    logic        cmp_start_q, cmp_start_d;
    logic        frame_ok_q, frame_ok_d;
    logic        frame_err_q, frame_err_d;
    logic        rx_drop_q, rx_drop_d;

    logic        timer_clear_s;
    logic        timer_en_s;
    logic        timer_expired_s;
    logic        seq_busy_s;

    // Classify states: receive-phase states run the gap timer, the
    // compare/transmit states drop incoming bytes.
    always_comb begin
        timer_en_s = 1'b0;
        seq_busy_s = 1'b0;
        case (state_q)
            ST_PA_HI, ST_PA_LO, ST_PB_HI, ST_PB_LO, ST_FOOTER: timer_en_s = 1'b1;
            ST_LAUNCH, ST_WAIT_CMP, ST_TX_LOAD, ST_TX_GAP, ST_TX_WAIT: seq_busy_s = 1'b1;
            default: begin
                timer_en_s = 1'b0;
                seq_busy_s = 1'b0;
            end
        endcase
    end

    assign timer_clear_s = rx_valid | (state_q == ST_IDLE);

    rx_gap_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_gap_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear_s),
        .enable  (timer_en_s),
        .expired (timer_expired_s)
    );

    // Next-state and registered-output logic of the frame sequencer.
    always_comb begin
        state_d     = state_q;
        a_stage_d   = a_stage_q;
        b_stage_d   = b_stage_q;
        price_a_d   = price_a_q;
        price_b_d   = price_b_q;
        action_d    = action_q;
        profit_d    = profit_q;
        idx_d       = idx_q;
        tx_data_d   = tx_data_q;
        tx_start_d  = 1'b0;
        cmp_start_d = 1'b0;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        rx_drop_d   = rx_valid & seq_busy_s;

        case (state_q)
            ST_IDLE: begin
                if (rx_valid && (rx_data == HDR_BYTE)) begin
                    state_d = ST_PA_HI;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PA_HI, ST_PA_LO, ST_PB_HI, ST_PB_LO, ST_FOOTER: begin
                if (rx_valid) begin
                    case (state_q)
                        ST_PA_HI: begin
                            a_stage_d[15:8] = rx_data;
                            state_d         = ST_PA_LO;
                        end
                        ST_PA_LO: begin
                            a_stage_d[7:0] = rx_data;
                            state_d        = ST_PB_HI;
                        end
                        ST_PB_HI: begin
                            b_stage_d[15:8] = rx_data;
                            state_d         = ST_PB_LO;
                        end
                        ST_PB_LO: begin
                            b_stage_d[7:0] = rx_data;
                            state_d        = ST_FOOTER;
                        end
                        default: begin
                            // Only an accepted footer publishes the staged prices.
                            if (rx_data == FTR_BYTE) begin
                                frame_ok_d  = 1'b1;
                                cmp_start_d = 1'b1;
                                price_a_d   = a_stage_q;
                                price_b_d   = b_stage_q;
                                state_d     = ST_LAUNCH;
                            end else begin
                                frame_err_d = 1'b1;
                                state_d     = ST_IDLE;
                            end
                        end
                    endcase
                end else if (timer_expired_s) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT_CMP;
            end
            ST_WAIT_CMP: begin
                if (cmp_done) begin
                    action_d = cmp_action;
                    profit_d = cmp_profit;
                    idx_d    = 3'd0;
                    state_d  = ST_TX_LOAD;
                end else begin
                    state_d = ST_WAIT_CMP;
                end
            end
            ST_TX_LOAD: begin
                if (!tx_busy) begin
                    tx_data_d  = resp_byte(idx_q, action_q, profit_q, HDR_BYTE, FTR_BYTE);
                    tx_start_d = 1'b1;
                    state_d    = ST_TX_GAP;
                end else begin
                    state_d = ST_TX_LOAD;
                end
            end
            ST_TX_GAP: begin
                // The transmitter raises tx_busy only one cycle after tx_start.
                state_d = ST_TX_WAIT;
            end
            ST_TX_WAIT: begin
                if (!tx_busy) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'(RESP_LEN - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_TX_LOAD;
                    end
                end else begin
                    state_d = ST_TX_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and output registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            a_stage_q   <= 16'h0000;
            b_stage_q   <= 16'h0000;
            price_a_q   <= 16'h0000;
            price_b_q   <= 16'h0000;
            action_q    <= ACT_NONE;
            profit_q    <= 16'h0000;
            idx_q       <= 3'd0;
            tx_data_q   <= 8'h00;
            tx_start_q  <= 1'b0;
            cmp_start_q <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            rx_drop_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_stage_q   <= a_stage_d;
            b_stage_q   <= b_stage_d;
            price_a_q   <= price_a_d;
            price_b_q   <= price_b_d;
            action_q    <= action_d;
            profit_q    <= profit_d;
            idx_q       <= idx_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            cmp_start_q <= cmp_start_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            rx_drop_q   <= rx_drop_d;
        end
    end

    assign cmp_price_a = price_a_q;
    assign cmp_price_b = price_b_q;
    assign cmp_start   = cmp_start_q;
    assign tx_data     = tx_data_q;
    assign tx_start    = tx_start_q;
    assign frame_ok    = frame_ok_q;
    assign frame_err   = frame_err_q;
    assign rx_drop     = rx_drop_q;

endmodule

// File: tb/tb_arb_frame_controller.sv
// Directed self-checking bench for arb_frame_controller with a small
// behavioural UART transmitter and hand-computed expected values.
module tb_arb_frame_controller;

    localparam int unsigned TO = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [15:0] cmp_price_a;
    logic [15:0] cmp_price_b;
    logic        cmp_start;
    logic        cmp_done = 1'b0;
    logic [1:0]  cmp_action = 2'd0;
    logic [15:0] cmp_profit = 16'h0000;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy = 1'b0;
    logic        frame_ok;
    logic        frame_err;
    logic        rx_drop;

    int checks = 0;
    int errors = 0;

    int frame_ok_cnt = 0;
    int frame_err_cnt = 0;
    int cmp_start_cnt = 0;
    int rx_drop_cnt = 0;
    int viol_cnt = 0;
    int tx_cnt = 0;
    logic [7:0] tx_log [64];

    arb_frame_controller #(
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .cmp_price_a (cmp_price_a),
        .cmp_price_b (cmp_price_b),
        .cmp_start   (cmp_start),
        .cmp_done    (cmp_done),
        .cmp_action  (cmp_action),
        .cmp_profit  (cmp_profit),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .frame_ok    (frame_ok),
        .frame_err   (frame_err),
        .rx_drop     (rx_drop)
    );

    initial begin
        forever #5 clk = ~clk;
    end

    // Transmitter model plus pulse counters, sampled 1 time unit after each edge.
    initial begin
        int         busy_cnt;
        bit         start_seen;
        logic [7:0] busy_data;
        busy_cnt   = 0;
        start_seen = 1'b0;
        busy_data  = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                busy_cnt   = 0;
                start_seen = 1'b0;
                tx_busy    = 1'b0;
            end else begin
                if (tx_busy && (tx_data !== busy_data)) viol_cnt++;
                if (busy_cnt > 0) begin
                    busy_cnt--;
                    if (busy_cnt == 0) tx_busy = 1'b0;
                end
                if (start_seen) begin
                    tx_busy    = 1'b1;
                    busy_cnt   = 6;
                    start_seen = 1'b0;
                end
                if (tx_start === 1'b1) begin
                    if (tx_busy) viol_cnt++;
                    if (tx_cnt < 64) tx_log[tx_cnt] = tx_data;
                    tx_cnt++;
                    busy_data  = tx_data;
                    start_seen = 1'b1;
                end
            end
            if (frame_ok === 1'b1) frame_ok_cnt++;
            if (frame_err === 1'b1) frame_err_cnt++;
            if (cmp_start === 1'b1) cmp_start_cnt++;
            if (rx_drop === 1'b1) rx_drop_cnt++;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        send_byte(b3);
        send_byte(b4);
        send_byte(b5);
    endtask

    task automatic do_cmp(input logic [1:0] act, input logic [15:0] prof);
        @(negedge clk);
        cmp_action = act;
        cmp_profit = prof;
        cmp_done   = 1'b1;
        @(negedge clk);
        cmp_done   = 1'b0;
        cmp_action = 2'd0;
        cmp_profit = 16'h0000;
    endtask

    task automatic wait_tx(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (tx_cnt >= target) break;
            @(negedge clk);
        end
        ok = (tx_cnt >= target);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (cmp_start !== 1'b0) begin errors++; $display("FAIL reset_cmp_start got %b want 0", cmp_start); end
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got %b want 0", tx_start); end
        checks++; if ({frame_ok, frame_err, rx_drop} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {frame_ok, frame_err, rx_drop}); end
        checks++; if ({cmp_price_a, cmp_price_b} !== 32'h0) begin errors++; $display("FAIL reset_prices got %h want 0", {cmp_price_a, cmp_price_b}); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_good_frame();
        int s_base;
        s_base = cmp_start_cnt;
        send_frame(8'hAA, 8'h10, 8'hAE, 8'h10, 8'h8B, 8'h55);
        checks++; if (frame_ok !== 1'b1) begin errors++; $display("FAIL good_frame_ok got %b want 1", frame_ok); end
        checks++; if (cmp_start !== 1'b1) begin errors++; $display("FAIL good_cmp_start_timing got %b want 1", cmp_start); end
        checks++; if (cmp_price_a !== 16'h10AE) begin errors++; $display("FAIL good_price_a got %h want 10ae", cmp_price_a); end
        checks++; if (cmp_price_b !== 16'h108B) begin errors++; $display("FAIL good_price_b got %h want 108b", cmp_price_b); end
        repeat (3) @(negedge clk);
        checks++; if (cmp_start_cnt - s_base !== 1) begin errors++; $display("FAIL good_cmp_start_count got %0d want 1", cmp_start_cnt - s_base); end
    endtask

    task automatic test_response();
        int         t_base;
        int         d_base;
        int         v_base;
        bit         ok;
        logic [7:0] exp [5];
        exp[0] = 8'hAA; exp[1] = 8'h02; exp[2] = 8'h00; exp[3] = 8'h23; exp[4] = 8'h55;
        t_base = tx_cnt;
        d_base = rx_drop_cnt;
        v_base = viol_cnt;
        do_cmp(2'd2, 16'h0023);
        wait_tx(t_base + 1, ok);
        send_byte(8'hAA);
        checks++; if (rx_drop !== 1'b1) begin errors++; $display("FAIL resp_rx_drop got %b want 1", rx_drop); end
        wait_tx(t_base + 5, ok);
        checks++; if (!ok) begin errors++; $display("FAIL resp_timeout got %0d bytes want 5", tx_cnt - t_base); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (tx_log[t_base + i] !== exp[i]) begin
                errors++; $display("FAIL resp_byte%0d got %h want %h", i, tx_log[t_base + i], exp[i]);
            end
        end
        repeat (12) @(negedge clk);
        checks++; if (tx_cnt - t_base !== 5) begin errors++; $display("FAIL resp_byte_count got %0d want 5", tx_cnt - t_base); end
        checks++; if (viol_cnt !== v_base) begin errors++; $display("FAIL resp_tx_protocol got %0d violations want 0", viol_cnt - v_base); end
        checks++; if (rx_drop_cnt - d_base !== 1) begin errors++; $display("FAIL resp_drop_count got %0d want 1", rx_drop_cnt - d_base); end
    endtask

    task automatic test_bad_footer();
        int  e_base;
        int  s_base;
        int  t_base;
        bit  ok;
        e_base = frame_err_cnt;
        s_base = cmp_start_cnt;
        send_frame(8'hAA, 8'h10, 8'hAE, 8'h10, 8'h8B, 8'h54);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL bad_frame_err got %b want 1", frame_err); end
        repeat (3) @(negedge clk);
        checks++; if (frame_err_cnt - e_base !== 1) begin errors++; $display("FAIL bad_err_count got %0d want 1", frame_err_cnt - e_base); end
        checks++; if (cmp_start_cnt !== s_base) begin errors++; $display("FAIL bad_no_cmp_start got %0d want 0", cmp_start_cnt - s_base); end
        checks++; if ({cmp_price_a, cmp_price_b} !== 32'h10AE_108B) begin errors++; $display("FAIL bad_prices_held got %h want 10ae108b", {cmp_price_a, cmp_price_b}); end
        send_frame(8'hAA, 8'h00, 8'h64, 8'h00, 8'hC8, 8'h55);
        checks++; if (frame_ok !== 1'b1) begin errors++; $display("FAIL bad_next_frame_ok got %b want 1", frame_ok); end
        checks++; if ({cmp_price_a, cmp_price_b} !== 32'h0064_00C8) begin errors++; $display("FAIL bad_next_prices got %h want 006400c8", {cmp_price_a, cmp_price_b}); end
        t_base = tx_cnt;
        do_cmp(2'd0, 16'h0000);
        wait_tx(t_base + 5, ok);
        checks++; if (!ok || tx_log[t_base + 1] !== 8'h00) begin errors++; $display("FAIL bad_next_action_byte got %h want 00", tx_log[t_base + 1]); end
        repeat (12) @(negedge clk);
    endtask

    task automatic test_timeout();
        int  e_base;
        int  s_base;
        int  t_base;
        bit  ok;
        e_base = frame_err_cnt;
        s_base = cmp_start_cnt;
        send_byte(8'hAA);
        send_byte(8'h10);
        repeat (TO + 10) @(negedge clk);
        checks++; if (frame_err_cnt - e_base !== 1) begin errors++; $display("FAIL timeout_err_count got %0d want 1", frame_err_cnt - e_base); end
        checks++; if (cmp_start_cnt !== s_base) begin errors++; $display("FAIL timeout_no_cmp_start got %0d want 0", cmp_start_cnt - s_base); end
        // Gaps just under the limit must not abort the frame.
        send_byte(8'hAA);
        repeat (TO - 5) @(negedge clk);
        send_byte(8'h00);
        send_byte(8'h01);
        repeat (TO - 5) @(negedge clk);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h55);
        checks++; if (frame_ok !== 1'b1) begin errors++; $display("FAIL timeout_next_frame_ok got %b want 1", frame_ok); end
        checks++; if ({cmp_price_a, cmp_price_b} !== 32'h0001_0002) begin errors++; $display("FAIL timeout_next_prices got %h want 00010002", {cmp_price_a, cmp_price_b}); end
        checks++; if (frame_err_cnt - e_base !== 1) begin errors++; $display("FAIL timeout_slow_frame_err got %0d want 1", frame_err_cnt - e_base); end
        t_base = tx_cnt;
        do_cmp(2'd1, 16'h0005);
        wait_tx(t_base + 5, ok);
        checks++; if (!ok || tx_log[t_base + 3] !== 8'h05) begin errors++; $display("FAIL timeout_profit_lo got %h want 05", tx_log[t_base + 3]); end
        repeat (12) @(negedge clk);
    endtask

    task automatic test_noise();
        int  e_base;
        int  t_base;
        bit  ok;
        e_base = frame_err_cnt;
        t_base = tx_cnt;
        send_byte(8'h00);
        send_byte(8'h55);
        do_cmp(2'd3, 16'hFFFF);
        repeat (10) @(negedge clk);
        checks++; if (frame_err_cnt !== e_base) begin errors++; $display("FAIL noise_no_err got %0d want 0", frame_err_cnt - e_base); end
        checks++; if (tx_cnt !== t_base) begin errors++; $display("FAIL noise_stray_cmp_done got %0d bytes want 0", tx_cnt - t_base); end
        send_frame(8'hAA, 8'hAA, 8'h01, 8'hAA, 8'h02, 8'h55);
        checks++; if (frame_ok !== 1'b1) begin errors++; $display("FAIL noise_frame_ok got %b want 1", frame_ok); end
        checks++; if ({cmp_price_a, cmp_price_b} !== 32'hAA01_AA02) begin errors++; $display("FAIL noise_hdr_as_data got %h want aa01aa02", {cmp_price_a, cmp_price_b}); end
        do_cmp(2'd3, 16'hBEEF);
        wait_tx(t_base + 5, ok);
        checks++; if (!ok || tx_log[t_base + 1] !== 8'h03 || tx_log[t_base + 2] !== 8'hBE) begin
            errors++; $display("FAIL noise_resp got %h %h want 03 be", tx_log[t_base + 1], tx_log[t_base + 2]);
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset_mid_tx();
        int  t_base;
        bit  ok;
        send_frame(8'hAA, 8'h01, 8'h00, 8'h02, 8'h00, 8'h55);
        t_base = tx_cnt;
        do_cmp(2'd1, 16'h0100);
        wait_tx(t_base + 3, ok);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (tx_start !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL rstmid_tx got %b/%h want 0/00", tx_start, tx_data); end
        checks++; if ({cmp_price_a, cmp_price_b} !== 32'h0) begin errors++; $display("FAIL rstmid_prices got %h want 0", {cmp_price_a, cmp_price_b}); end
        rst = 1'b1;
        repeat (30) @(negedge clk);
        checks++; if (tx_cnt - t_base !== 3) begin errors++; $display("FAIL rstmid_not_resumed got %0d bytes want 3", tx_cnt - t_base); end
        send_frame(8'hAA, 8'h12, 8'h34, 8'h56, 8'h78, 8'h55);
        checks++; if (frame_ok !== 1'b1 || cmp_price_a !== 16'h1234 || cmp_price_b !== 16'h5678) begin
            errors++; $display("FAIL rstmid_next_frame got %b %h %h want 1 1234 5678", frame_ok, cmp_price_a, cmp_price_b);
        end
        t_base = tx_cnt;
        do_cmp(2'd2, 16'h0042);
        wait_tx(t_base + 5, ok);
        checks++; if (!ok || tx_log[t_base] !== 8'hAA || tx_log[t_base + 4] !== 8'h55) begin
            errors++; $display("FAIL rstmid_next_resp got %h..%h want aa..55", tx_log[t_base], tx_log[t_base + 4]);
        end
        repeat (12) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_response();
        test_bad_footer();
        test_timeout();
        test_noise();
        test_reset_mid_tx();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
